// File: rtl/inst_fetch_decode.sv
// rtl/inst_fetch_decode.sv - byte-serial fetch and registered decode front end for the 8-bit core
// Optional HALT state enabled by defining IFD_HALT_EN; otherwise MOV MS=00 decodes as a NOP.
module inst_fetch_decode (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] PC,
    output logic [9:0] PM_ADDR,
    input  logic [7:0] PM_DATA,
    output logic       EXEC_STB,
    output logic       MEM_INST,
    output logic       ALU_INST,
    output logic       JMP_INST,
    output logic       IRS,
    output logic [1:0] MS,
    output logic [2:0] RS,
    output logic [2:0] AR,
    output logic [2:0] BS,
    output logic [3:0] OP,
    output logic [7:0] IMM,
    output logic       HALTED
);

    typedef enum logic [2:0] {F0, F1, F2, F3, EXEC, HALT} state_t;

    state_t     state, next_state;
    logic [7:0] b0, b1;
    logic [1:0] bi;
    logic       need_imm, halt_dec;
    logic [7:0] dec_b1, dec_imm;
    logic       d_mem, d_alu, d_jmp, d_irs;
    logic [1:0] d_ms;
    logic [2:0] d_rs, d_ar, d_bs;
    logic [3:0] d_op;
    logic [7:0] d_imm;

    assign PM_ADDR = {PC, bi};

    // In F2 the live PM_DATA is B1, so length and HALT are known before B1 is registered.
    always_comb begin
        bi       = 2'd0;
        need_imm = 1'b0;
        halt_dec = 1'b0;
        case (state)
            F1:      bi = 2'd1;
            F2:      bi = 2'd2;
            default: bi = 2'd0;
        endcase
        case (b0[7:6])
            2'b00, 2'b11: need_imm = PM_DATA[3];
            2'b01:        need_imm = (PM_DATA[5:4] == 2'b10);
            default:      need_imm = 1'b1;
        endcase
`ifdef IFD_HALT_EN
        halt_dec = (b0[7:6] == 2'b01) && (PM_DATA[5:4] == 2'b00);
`endif
        next_state = state;
        case (state)
            F0:   next_state = F1;
            F1:   next_state = F2;
            F2: begin
                if (halt_dec)      next_state = HALT;
                else if (need_imm) next_state = F3;
                else               next_state = EXEC;
            end
            F3:   next_state = EXEC;
            EXEC: next_state = F0;
            HALT: next_state = HALT;
            default: next_state = F0;
        endcase
    end

    // Decode source: B1 is live in F2 and registered in F3; the immediate exists only in F3.
    always_comb begin
        dec_b1  = (state == F3) ? b1 : PM_DATA;
        dec_imm = (state == F3) ? PM_DATA : 8'd0;
        d_mem   = 1'b0;
        d_alu   = 1'b0;
        d_jmp   = 1'b0;
        d_irs   = 1'b0;
        d_ms    = 2'b00;
        d_rs    = 3'd0;
        d_ar    = 3'd0;
        d_bs    = 3'd0;
        d_op    = 4'd0;
        d_imm   = 8'd0;
        case (b0[7:6])
            2'b00, 2'b11: begin
                d_alu = 1'b1;
                d_mem = (b0[7:6] == 2'b00);
                d_rs  = b0[5:3];
                d_ar  = b0[2:0];
                d_op  = dec_b1[7:4];
                d_irs = dec_b1[3];
                d_bs  = dec_b1[2:0];
                d_imm = dec_imm;
            end
            2'b01: begin
                if (dec_b1[5:4] != 2'b00) begin
                    d_mem = 1'b1;
                    d_ms  = dec_b1[5:4];
                    d_rs  = b0[5:3];
                    d_ar  = b0[2:0];
                    d_bs  = dec_b1[2:0];
                    d_imm = dec_imm;
                end
            end
            default: begin
                d_jmp = 1'b1;
                d_op  = dec_b1[7:4];
                d_imm = dec_imm;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= F0;
            b0       <= 8'd0;
            b1       <= 8'd0;
            EXEC_STB <= 1'b0;
            MEM_INST <= 1'b0;
            ALU_INST <= 1'b0;
            JMP_INST <= 1'b0;
            IRS      <= 1'b0;
            MS       <= 2'b00;
            RS       <= 3'd0;
            AR       <= 3'd0;
            BS       <= 3'd0;
            OP       <= 4'd0;
            IMM      <= 8'd0;
        end else begin
            state <= next_state;
            if (state == F1) b0 <= PM_DATA;
            if (state == F2) b1 <= PM_DATA;
            EXEC_STB <= (next_state == EXEC);
            if (next_state == EXEC) begin
                MEM_INST <= d_mem;
                ALU_INST <= d_alu;
                JMP_INST <= d_jmp;
                IRS      <= d_irs;
                MS       <= d_ms;
                RS       <= d_rs;
                AR       <= d_ar;
                BS       <= d_bs;
                OP       <= d_op;
                IMM      <= d_imm;
            end else begin
                MEM_INST <= 1'b0;
                ALU_INST <= 1'b0;
                JMP_INST <= 1'b0;
                IRS      <= 1'b0;
                MS       <= 2'b00;
                RS       <= 3'd0;
                AR       <= 3'd0;
                BS       <= 3'd0;
                OP       <= 4'd0;
                IMM      <= 8'd0;
            end
        end
    end

`ifdef IFD_HALT_EN
    always_ff @(posedge CLK) begin
        if (RST) HALTED <= 1'b0;
        else     HALTED <= (next_state == HALT);
    end
`else
    assign HALTED = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_decode.sv
// tb/tb_inst_fetch_decode.sv - directed vector bench for inst_fetch_decode
module tb_inst_fetch_decode;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pc;
    logic [9:0] pm_addr;
    logic [7:0] pm_data;
    logic       exec_stb, mem_inst, alu_inst, jmp_inst, irs, halted;
    logic [1:0] ms;
    logic [2:0] rs, ar, bs;
    logic [3:0] op;
    logic [7:0] imm;
    logic [26:0] ctl;
    logic [7:0] mem [1024];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) pm_data <= mem[pm_addr];

    assign ctl = {mem_inst, alu_inst, jmp_inst, irs, ms, rs, ar, bs, op, imm};

    inst_fetch_decode dut (
        .CLK(clk), .RST(rst), .PC(pc), .PM_ADDR(pm_addr), .PM_DATA(pm_data),
        .EXEC_STB(exec_stb), .MEM_INST(mem_inst), .ALU_INST(alu_inst), .JMP_INST(jmp_inst),
        .IRS(irs), .MS(ms), .RS(rs), .AR(ar), .BS(bs), .OP(op), .IMM(imm), .HALTED(halted)
    );

    typedef struct {
        string      name;
        logic [7:0] b0, b1, b2, pc;
        int         len;
        logic [26:0] exp_ctl;
    } vec_t;

    vec_t vecs [$];

    function automatic logic [26:0] mk(input int m, input int a, input int j, input int i,
                                       input int s, input int r, input int x, input int b,
                                       input int o, input int im);
        return {1'(m), 1'(a), 1'(j), 1'(i), 2'(s), 3'(r), 3'(x), 3'(b), 4'(o), 8'(im)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Starts at posedge+1 of an F0 cycle; returns at posedge+1 after the EXEC edge.
    task automatic run_vec(input vec_t v);
        logic       seen, quiet;
        logic [1:0] b;
        mem[{v.pc, 2'd0}] = v.b0;
        mem[{v.pc, 2'd1}] = v.b1;
        mem[{v.pc, 2'd2}] = v.b2;
        pc = v.pc;
        seen = 1'b0;
        quiet = 1'b1;
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(negedge clk);
            if (c <= 3) begin
                b = 2'(c - 1);
                chk({v.name, "_addr"}, 32'(pm_addr), 32'({v.pc, b}));
            end
            if (exec_stb) begin
                seen = 1'b1;
                chk({v.name, "_latency"}, 32'(c), 32'(v.len));
                chk({v.name, "_ctl"}, 32'(ctl), 32'(v.exp_ctl));
            end else if (ctl != 27'd0 || halted) begin
                quiet = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        chk({v.name, "_strobe_seen"}, 32'(seen), 32'd1);
        chk({v.name, "_quiet_fetch"}, 32'(quiet), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        vecs.push_back('{"mov_imm",   8'b01_001_000, 8'b0010_0000, 8'd20,  8'd1,   5, mk(1,0,0,0,2,1,0,0,0,20)});
        vecs.push_back('{"alu_rr",    8'b11_000_000, 8'b1000_0_001, 8'd0,  8'd2,   4, mk(0,1,0,0,0,0,0,1,8,0)});
        vecs.push_back('{"jmp",       8'b10_000_000, 8'b0100_0000, 8'd20,  8'd4,   5, mk(0,0,1,0,0,0,0,0,4,20)});
        vecs.push_back('{"alu_wb_imm",8'b00_010_011, 8'b0011_1_101, 8'h5A, 8'd20,  5, mk(1,1,0,1,0,2,3,5,3,8'h5A)});
        vecs.push_back('{"mov_rr",    8'b01_011_100, 8'b0001_0_010, 8'd0,  8'd21,  4, mk(1,0,0,0,1,3,4,2,0,0)});
        vecs.push_back('{"mov_ms11",  8'b01_101_001, 8'b1111_1_111, 8'd0,  8'd22,  4, mk(1,0,0,0,3,5,1,7,0,0)});
        vecs.push_back('{"alu_fl_imm",8'b11_111_111, 8'b1111_1_000, 8'hFF, 8'd23,  5, mk(0,1,0,1,0,7,7,0,15,8'hFF)});
        vecs.push_back('{"wrap_hi",   8'b00_001_010, 8'b0110_0_011, 8'd0,  8'd255, 4, mk(1,1,0,0,0,1,2,3,6,0)});
        vecs.push_back('{"wrap_lo",   8'b11_010_001, 8'b0000_0_100, 8'd0,  8'd0,   4, mk(0,1,0,0,0,2,1,4,0,0)});
`ifndef IFD_HALT_EN
        vecs.push_back('{"mov_nop",   8'b01_000_000, 8'b0000_0000, 8'd0,  8'd30,  4, mk(0,0,0,0,0,0,0,0,0,0)});
`endif

        rst = 1'b1;
        pc = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl", 32'(ctl), 32'd0);
        chk("reset_stb", 32'(exec_stb), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset while in F2: the partial instruction is dropped and fetch restarts at byte 0.
        pc = 8'd2;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_vec(vecs[1]);

        // Reset during EXEC.
        pc = 8'd2;
        for (int c = 0; c < 8 && !exec_stb; c++) @(negedge clk);
        chk("exec_reached", 32'(exec_stb), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_exec_stb", 32'(exec_stb), 32'd0);
        chk("rst_exec_ctl", 32'(ctl), 32'd0);
        chk("rst_exec_addr", 32'(pm_addr), 32'({8'd2, 2'd0}));
        run_vec(vecs[0]);

`ifdef IFD_HALT_EN
        begin
            logic ok_stb, ok_halt, ok_addr;
            mem[{8'd30, 2'd0}] = 8'b01_000_000;
            mem[{8'd30, 2'd1}] = 8'b0000_0000;
            pc = 8'd30;
            ok_stb = 1'b1; ok_halt = 1'b1; ok_addr = 1'b1;
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk);
                if (exec_stb) ok_stb = 1'b0;
                if (halted !== (c >= 4)) ok_halt = 1'b0;
                if (c >= 4 && pm_addr != {8'd30, 2'd0}) ok_addr = 1'b0;
            end
            chk("halt_no_stb", 32'(ok_stb), 32'd1);
            chk("halt_flag", 32'(ok_halt), 32'd1);
            chk("halt_addr", 32'(ok_addr), 32'd1);
            chk("halt_ctl", 32'(ctl), 32'd0);
            @(posedge clk);
            #1;
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            chk("halt_cleared", 32'(halted), 32'd0);
            run_vec(vecs[1]);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
